// File: rtl/mac_pe.sv
// Systolic multiply-accumulate processing element: forwards A/B/valid to the
// neighbouring PE and accumulates a pipelined signed product into Cout.
module mac_pe #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int PIPE    = 2,
  parameter int SAT     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      WrEn,
  input  logic                      clr,
  input  logic                      vin,
  input  logic signed [BITS_AB-1:0] Ain,
  input  logic signed [BITS_AB-1:0] Bin,
  input  logic signed [BITS_C-1:0]  Cin,
  output logic signed [BITS_AB-1:0] Aout,
  output logic signed [BITS_AB-1:0] Bout,
  output logic                      vout,
  output logic signed [BITS_C-1:0]  Cout,
  output logic                      ovf
);
  localparam int PW = 2 * BITS_AB;
  localparam logic [BITS_C-1:0] C_MAX = {1'b0, {(BITS_C-1){1'b1}}};
  localparam logic [BITS_C-1:0] C_MIN = {1'b1, {(BITS_C-1){1'b0}}};

  logic signed [BITS_AB-1:0] aout_q, aout_d, bout_q, bout_d;
  logic                      vout_q, vout_d;
  logic signed [BITS_C-1:0]  cout_q, cout_d;
  logic                      ovf_q, ovf_d;

  // Entry 0 is the live product/valid; entries 1..PIPE are registered stages.
  logic [PIPE:0][PW-1:0] prod_pipe;
  logic [PIPE:0]         vld_pipe;

  logic signed [PW-1:0] prod_in;
  assign prod_in      = PW'(Ain) * PW'(Bin);
  assign prod_pipe[0] = prod_in;
  assign vld_pipe[0]  = vin;

  generate
    if (PIPE > 0) begin : g_pipe
      logic [PIPE:1][PW-1:0] prod_q, prod_d;
      logic [PIPE:1]         vld_q, vld_d;

      always_comb begin
        prod_d = prod_q;
        vld_d  = vld_q;
        if (clr) begin
          vld_d = '0;
        end else if (en) begin
          prod_d = prod_pipe[PIPE-1:0];
          vld_d  = vld_pipe[PIPE-1:0];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          prod_q <= '0;
          vld_q  <= '0;
        end else begin
          prod_q <= prod_d;
          vld_q  <= vld_d;
        end
      end

      assign prod_pipe[PIPE:1] = prod_q;
      assign vld_pipe[PIPE:1]  = vld_q;
    end
  endgenerate

  // Forwarding ignores clr/WrEn; only en gates it.
  always_comb begin
    aout_d = aout_q;
    bout_d = bout_q;
    vout_d = vout_q;
    if (en) begin
      aout_d = Ain;
      bout_d = Bin;
      vout_d = vin;
    end
  end

  // One extra bit makes signed overflow visible as a top-two-bit disagreement.
  logic signed [BITS_C:0] sum;
  logic                   sum_ovf;
  assign sum     = (BITS_C+1)'(cout_q) + (BITS_C+1)'($signed(prod_pipe[PIPE]));
  assign sum_ovf = sum[BITS_C] ^ sum[BITS_C-1];

  always_comb begin
    cout_d = cout_q;
    ovf_d  = ovf_q;
    if (clr) begin
      cout_d = '0;
      ovf_d  = 1'b0;
    end else if (en) begin
      if (WrEn) begin
        cout_d = Cin;
      end else if (vld_pipe[PIPE]) begin
        cout_d = sum[BITS_C-1:0];
        if (sum_ovf) begin
          ovf_d = 1'b1;
          if (SAT != 0) cout_d = sum[BITS_C] ? C_MIN : C_MAX;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aout_q <= '0;
      bout_q <= '0;
      vout_q <= 1'b0;
      cout_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      aout_q <= aout_d;
      bout_q <= bout_d;
      vout_q <= vout_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign Aout = aout_q;
  assign Bout = bout_q;
  assign vout = vout_q;
  assign Cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_mac_pe.sv
// Drives three mac_pe variants (PIPE2/SAT, PIPE2/wrap, PIPE0/SAT) from one
// stimulus stream and compares each against an event-queue reference model.
module tb_mac_pe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, en, wren, clr, vin;
  logic signed [7:0]  ain, bin;
  logic signed [15:0] cin;
  logic signed [7:0]  aout_o [3];
  logic signed [7:0]  bout_o [3];
  logic               vout_o [3];
  logic signed [15:0] cout_o [3];
  logic               ovf_o  [3];

  mac_pe #(.BITS_AB(8), .BITS_C(16), .PIPE(2), .SAT(1)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .WrEn(wren), .clr(clr), .vin(vin),
    .Ain(ain), .Bin(bin), .Cin(cin), .Aout(aout_o[0]), .Bout(bout_o[0]),
    .vout(vout_o[0]), .Cout(cout_o[0]), .ovf(ovf_o[0]));
  mac_pe #(.BITS_AB(8), .BITS_C(16), .PIPE(2), .SAT(0)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .WrEn(wren), .clr(clr), .vin(vin),
    .Ain(ain), .Bin(bin), .Cin(cin), .Aout(aout_o[1]), .Bout(bout_o[1]),
    .vout(vout_o[1]), .Cout(cout_o[1]), .ovf(ovf_o[1]));
  mac_pe #(.BITS_AB(8), .BITS_C(16), .PIPE(0), .SAT(1)) dut_comb (
    .clk(clk), .rst(rst), .en(en), .WrEn(wren), .clr(clr), .vin(vin),
    .Ain(ain), .Bin(bin), .Cin(cin), .Aout(aout_o[2]), .Bout(bout_o[2]),
    .vout(vout_o[2]), .Cout(cout_o[2]), .ovf(ovf_o[2]));

  int checks = 0;
  int errors = 0;

  // Reference: each valid pair becomes an event due a fixed number of
  // enabled edges later; rst/clr cancel every pending event.
  typedef struct { int m; int due; int p; } pend_t;
  pend_t pend[$];
  int    en_cnt = 0;
  int    c_m [3];
  int    ovf_m [3];
  int    a_m, b_m, v_m;

  function automatic int pipe_of(int m); return (m == 2) ? 0 : 2; endfunction
  function automatic bit sat_of(int m);  return (m != 1);         endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int p, s;
    bit found;
    if (rst) begin
      pend.delete();
      a_m = 0; b_m = 0; v_m = 0;
      for (int m = 0; m < 3; m++) begin c_m[m] = 0; ovf_m[m] = 0; end
      return;
    end
    if (en) begin a_m = int'(ain); b_m = int'(bin); v_m = int'(vin); end
    if (clr) begin
      pend.delete();
      for (int m = 0; m < 3; m++) begin c_m[m] = 0; ovf_m[m] = 0; end
    end else if (en) begin
      en_cnt++;
      p = int'(ain) * int'(bin);
      if (vin) for (int m = 0; m < 3; m++) pend.push_back('{m, en_cnt + pipe_of(m), p});
      for (int m = 0; m < 3; m++) begin
        found = 0;
        s = 0;
        for (int i = pend.size() - 1; i >= 0; i--)
          if (pend[i].m == m && pend[i].due == en_cnt) begin
            found = 1;
            s = pend[i].p;
            pend.delete(i);
          end
        if (wren) c_m[m] = int'(cin);
        else if (found) begin
          s = c_m[m] + s;
          if (s > 32767) begin
            ovf_m[m] = 1;
            c_m[m] = sat_of(m) ? 32767 : s - 65536;
          end else if (s < -32768) begin
            ovf_m[m] = 1;
            c_m[m] = sat_of(m) ? -32768 : s + 65536;
          end else c_m[m] = s;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("cout%0d", m), int'(cout_o[m]), c_m[m]);
      chk($sformatf("ovf%0d", m),  int'(ovf_o[m]),  ovf_m[m]);
      chk($sformatf("aout%0d", m), int'(aout_o[m]), a_m);
      chk($sformatf("bout%0d", m), int'(bout_o[m]), b_m);
      chk($sformatf("vout%0d", m), int'(vout_o[m]), v_m);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit w, input bit c,
                      input bit v, input int a, input int b, input int ci);
    rst = r; en = e; wren = w; clr = c; vin = v;
    ain = 8'(a); bin = 8'(b); cin = 16'(ci);
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(); step(0, 1, 0, 0, 0, 0, 0, 0); endtask

  initial begin
    int r;
    int a, b;
    rst = 1; en = 0; wren = 0; clr = 0; vin = 0; ain = 0; bin = 0; cin = 0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);

    // Mid-operation reset with a valid pair at the reset edge
    step(0, 1, 0, 0, 1, 7, 7, 0);
    step(1, 1, 0, 0, 1, 5, 1, 0);
    for (int m = 0; m < 3; m++) begin
      chk("rst_cout", int'(cout_o[m]), 0);
      chk("rst_aout", int'(aout_o[m]), 0);
      chk("rst_vout", int'(vout_o[m]), 0);
    end
    repeat (3) idle();
    chk("rst_no_late", int'(cout_o[0]), 0);

    // Preload then one pair: 100 + 3*(-4)
    step(0, 1, 1, 0, 0, 0, 0, 100);
    chk("load_100", int'(cout_o[0]), 100);
    step(0, 1, 0, 0, 1, 3, -4, 0);
    chk("lat_hold0", int'(cout_o[0]), 100);
    chk("fwd_a3", int'(aout_o[0]), 3);
    chk("fwd_v1", int'(vout_o[0]), 1);
    idle();
    chk("lat_hold1", int'(cout_o[0]), 100);
    idle();
    chk("acc_88", int'(cout_o[0]), 88);

    // Saturating high clamp, then a small step down keeps ovf sticky
    step(0, 1, 0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0, 32700);
    step(0, 1, 0, 0, 1, 127, 127, 0);
    idle(); idle();
    chk("sat_max", int'(cout_o[0]), 32767);
    chk("sat_ovf", int'(ovf_o[0]), 1);
    step(0, 1, 0, 0, 1, -1, 1, 0);
    idle(); idle();
    chk("sat_dec", int'(cout_o[0]), 32766);
    chk("sat_ovf_sticky", int'(ovf_o[0]), 1);

    // Wrapping overflow
    step(0, 1, 0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0, 32767);
    step(0, 1, 0, 0, 1, 1, 1, 0);
    idle(); idle();
    chk("wrap_min", int'(cout_o[1]), -32768);
    chk("wrap_ovf", int'(ovf_o[1]), 1);

    // Freeze mid-pipeline: the product lands exactly once after resume
    step(0, 1, 0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 2, 2, 0);
    idle();
    repeat (3) begin
      step(0, 0, 0, 0, 1, 9, 9, 0);
      chk("frz_hold", int'(cout_o[0]), 0);
    end
    idle();
    chk("frz_once", int'(cout_o[0]), 4);
    idle(); idle();
    chk("frz_no_dup", int'(cout_o[0]), 4);

    // clr kills in-flight pairs
    step(0, 1, 1, 0, 0, 0, 0, 10);
    step(0, 1, 0, 0, 1, 1, 1, 0);
    step(0, 1, 0, 0, 1, 2, 2, 0);
    step(0, 1, 0, 1, 0, 0, 0, 0);
    chk("clr_cout", int'(cout_o[0]), 0);
    chk("clr_ovf", int'(ovf_o[0]), 0);
    repeat (3) idle();
    chk("clr_flush", int'(cout_o[0]), 0);

    // WrEn on a valid tail drops it; the younger pair still accumulates
    step(0, 1, 0, 0, 1, 5, 5, 0);
    step(0, 1, 0, 0, 1, 3, 3, 0);
    step(0, 1, 1, 0, 0, 0, 0, 7);
    chk("wr_drop", int'(cout_o[0]), 7);
    idle();
    chk("wr_keep", int'(cout_o[0]), 16);

    // Randomized phase, extremes weighted in to provoke overflow
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 3);
      a = (r == 0) ? (($urandom_range(0, 1) == 1) ? 127 : -128) : $urandom_range(0, 255) - 128;
      b = (r == 0) ? (($urandom_range(0, 1) == 1) ? 127 : -128) : $urandom_range(0, 255) - 128;
      step($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 85,
           $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 70, a, b, $urandom_range(0, 65535) - 32768);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
